// File: rtl/quad_pkg.sv
// Shared types and the quadrature step classifier used by every encoder channel.
// The 2-bit quadrature state is always packed as {a, b}.
package quad_pkg;

    typedef enum logic [1:0] {
        Q00 = 2'b00,
        Q01 = 2'b01,
        Q10 = 2'b10,
        Q11 = 2'b11
    } qstate_t;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_UP,
        STEP_DN,
        STEP_ERR
    } step_e;

    typedef enum logic {
        PH_WARM,
        PH_RUN
    } phase_t;

    // Clockwise successor: 00 -> 10 -> 11 -> 01 -> 00
    function automatic qstate_t cw_next(qstate_t s);
        case (s)
            Q00:     return Q10;
            Q10:     return Q11;
            Q11:     return Q01;
            default: return Q00;
        endcase
    endfunction

    function automatic step_e quad_step(qstate_t prev, qstate_t cur);
        if (cur == prev) begin
            return STEP_NONE;
        end else if (cur == cw_next(prev)) begin
            return STEP_UP;
        end else if (prev == cw_next(cur)) begin
            return STEP_DN;
        end else begin
            return STEP_ERR;
        end
    endfunction

endpackage

// File: rtl/quad_chan.sv
// One encoder channel: pin synchroniser, stability filter, x4 decode, position and revolution counters.
// state    | meaning
// PH_WARM  | sync/filter pipeline still filling after reset; prev_state only tracks the filter
// PH_RUN   | primed; every filtered change is decoded into a step or an error
module quad_chan
    import quad_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int CPR         = 48960,
    parameter int REV_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             err_clr,
    output logic [CNT_W-1:0] count,
    output logic [REV_W-1:0] rev_count,
    output logic             dir,
    output logic             step,
    output logic             wrap,
    output logic             err
);

    localparam int RUN_W  = $clog2(FILT_LEN + 1);
    localparam int WARM   = SYNC_STAGES + FILT_LEN;
    localparam int WARM_W = $clog2(WARM + 1);

    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    qstate_t                synced;

    qstate_t                filt;
    qstate_t                cand;
    logic [RUN_W-1:0]       run;
    logic [RUN_W-1:0]       run_next;
    logic                   run_stable;

    phase_t                 state;
    phase_t                 state_next;
    logic [WARM_W-1:0]      warm;
    logic                   decode_en;

    qstate_t                prev_state;
    step_e                  kind;
    logic [CNT_W-1:0]       load_sat;
    logic                   at_top;
    logic                   at_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], a};
            sync_b <= {sync_b[SYNC_STAGES-2:0], b};
        end
    end

    assign synced = qstate_t'({sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]});

    // A run only continues while the synced value matches the candidate it started with
    always_comb begin
        run_stable = (run == '0) || (synced == cand);
        run_next   = run_stable ? run + RUN_W'(1) : RUN_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt <= Q00;
            cand <= Q00;
            run  <= '0;
        end else if (synced == filt) begin
            run <= '0;
        end else if (run_next == RUN_W'(FILT_LEN)) begin
            filt <= synced;
            run  <= '0;
        end else begin
            cand <= synced;
            run  <= run_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= PH_WARM;
            warm  <= WARM_W'(WARM);
        end else begin
            state <= state_next;
            if (state == PH_WARM && warm != '0) begin
                warm <= warm - WARM_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        decode_en  = 1'b0;
        case (state)
            PH_WARM: begin
                if (warm == '0) begin
                    state_next = PH_RUN;
                end
            end
            PH_RUN: begin
                decode_en = 1'b1;
            end
            default: begin
                state_next = PH_WARM;
            end
        endcase
    end

    always_comb begin
        kind     = decode_en ? quad_step(prev_state, filt) : STEP_NONE;
        load_sat = (load_val >= CNT_W'(CPR)) ? CNT_W'(CPR - 1) : load_val;
        at_top   = (count == CNT_W'(CPR - 1));
        at_zero  = (count == '0);
    end

    // prev_state follows the filter every cycle, so clear/load/err never desynchronise the decoder
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_state <= Q00;
            count      <= '0;
            rev_count  <= '0;
            dir        <= 1'b0;
            step       <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            prev_state <= filt;
            step       <= 1'b0;
            wrap       <= 1'b0;
            if (clear) begin
                count     <= '0;
                rev_count <= '0;
            end else if (load) begin
                count <= load_sat;
            end else begin
                case (kind)
                    STEP_UP: begin
                        dir  <= 1'b1;
                        step <= 1'b1;
                        if (at_top) begin
                            count     <= '0;
                            rev_count <= rev_count + REV_W'(1);
                            wrap      <= 1'b1;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                    STEP_DN: begin
                        dir  <= 1'b0;
                        step <= 1'b1;
                        if (at_zero) begin
                            count     <= CNT_W'(CPR - 1);
                            rev_count <= rev_count - REV_W'(1);
                            wrap      <= 1'b1;
                        end else begin
                            count <= count - CNT_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (kind == STEP_ERR) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

endmodule

// File: rtl/quad_decoder_multi.sv
// N-channel quadrature decoder: one independent quad_chan per encoder axis, outputs packed per channel.
module quad_decoder_multi
    import quad_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int CNT_W       = 32,
    parameter int CPR         = 48960,
    parameter int REV_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       a,
    input  logic [N_CH-1:0]       b,
    input  logic [N_CH-1:0]       clear,
    input  logic [N_CH-1:0]       load,
    input  logic [N_CH*CNT_W-1:0] load_val,
    input  logic [N_CH-1:0]       err_clr,
    output logic [N_CH*CNT_W-1:0] count,
    output logic [N_CH*REV_W-1:0] rev_count,
    output logic [N_CH-1:0]       dir,
    output logic [N_CH-1:0]       step,
    output logic [N_CH-1:0]       wrap,
    output logic [N_CH-1:0]       err
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        quad_chan #(
            .CNT_W       (CNT_W),
            .CPR         (CPR),
            .REV_W       (REV_W),
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_LEN    (FILT_LEN)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .a         (a[g]),
            .b         (b[g]),
            .clear     (clear[g]),
            .load      (load[g]),
            .load_val  (load_val[g*CNT_W +: CNT_W]),
            .err_clr   (err_clr[g]),
            .count     (count[g*CNT_W +: CNT_W]),
            .rev_count (rev_count[g*REV_W +: REV_W]),
            .dir       (dir[g]),
            .step      (step[g]),
            .wrap      (wrap[g]),
            .err       (err[g])
        );
    end

endmodule

// File: tb/tb_quad_decoder_multi.sv
// Bench for quad_decoder_multi: pin-level stimulus, expected step results queued per channel and
// checked by an independent monitor whenever a step pulse appears.
module tb_quad_decoder_multi;

    localparam int N_CH  = 2;
    localparam int CNT_W = 32;
    localparam int CPR   = 8;
    localparam int REV_W = 16;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [N_CH-1:0]       a = '0;
    logic [N_CH-1:0]       b = '0;
    logic [N_CH-1:0]       clear = '0;
    logic [N_CH-1:0]       load = '0;
    logic [N_CH*CNT_W-1:0] load_val = '0;
    logic [N_CH-1:0]       err_clr = '0;
    logic [N_CH*CNT_W-1:0] count;
    logic [N_CH*REV_W-1:0] rev_count;
    logic [N_CH-1:0]       dir;
    logic [N_CH-1:0]       step;
    logic [N_CH-1:0]       wrap;
    logic [N_CH-1:0]       err;

    quad_decoder_multi #(
        .N_CH(N_CH), .CNT_W(CNT_W), .CPR(CPR), .REV_W(REV_W), .SYNC_STAGES(2), .FILT_LEN(3)
    ) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .clear(clear), .load(load), .load_val(load_val),
        .err_clr(err_clr), .count(count), .rev_count(rev_count), .dir(dir), .step(step),
        .wrap(wrap), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pos;
        int rev;
        bit dir;
        bit wrp;
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    exp_t       mon_e;
    int         errors = 0;
    int         checks = 0;
    int         pos[2];
    int         rev[2];
    int         ph[2];
    int         wraps_seen[2];
    logic [1:0] seq[4];
    bit         early, st, wr;

    function automatic void chk(string nm, longint act_v, longint exp_v);
        checks++;
        if (act_v != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act_v, exp_v, $time);
        end
    endfunction

    function automatic longint cnt_of(int c);
        return longint'(count[c*CNT_W +: CNT_W]);
    endfunction

    function automatic longint rev_of(int c);
        return longint'(rev_count[c*REV_W +: REV_W]);
    endfunction

    // Reference model: position on a circle of CPR counts, revolutions as a plain integer.
    function automatic void model_step(int c, int d);
        exp_t e;
        bit   w;
        if (d > 0) begin
            w = (pos[c] == CPR - 1);
            pos[c] = (pos[c] + 1) % CPR;
            if (w) rev[c] = rev[c] + 1;
        end else begin
            w = (pos[c] == 0);
            pos[c] = (pos[c] + CPR - 1) % CPR;
            if (w) rev[c] = rev[c] - 1;
        end
        e.pos = pos[c];
        e.rev = rev[c];
        e.dir = (d > 0);
        e.wrp = w;
        if (c == 0) q0.push_back(e);
        else q1.push_back(e);
    endfunction

    function automatic void apply_move(int c, int d, bit counted);
        ph[c] = (ph[c] + d + 4) % 4;
        if (counted && (d == 1 || d == -1)) model_step(c, d);
        a[c] = seq[ph[c]][1];
        b[c] = seq[ph[c]][0];
    endfunction

    // Pin move on one channel; ctl (1 load, 2 clear, 3 err_clr) is asserted on the decode edge, 6 clocks later.
    task automatic act(input int c, input int d, input int ctl, input int val,
                       output bit early_o, output bit st_o, output bit wr_o);
        @(negedge clk);
        apply_move(c, d, ctl == 0);
        early_o = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (step[c]) early_o = 1'b1;
        end
        @(negedge clk);
        case (ctl)
            1: begin load[c] = 1'b1; load_val[c*CNT_W +: CNT_W] = val; end
            2: clear[c] = 1'b1;
            3: err_clr[c] = 1'b1;
            default: ;
        endcase
        @(posedge clk);
        #1;
        st_o = step[c];
        wr_o = wrap[c];
        @(negedge clk);
        load = '0;
        clear = '0;
        err_clr = '0;
        if (ctl == 1) pos[c] = (val >= CPR) ? CPR - 1 : val;
        if (ctl == 2) begin pos[c] = 0; rev[c] = 0; end
        repeat (3) @(posedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        for (int c = 0; c < N_CH; c++) begin
            if (step[c]) begin
                if ((c == 0 && q0.size() == 0) || (c == 1 && q1.size() == 0)) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_step ch%0d: got count %0d with no step expected", c, cnt_of(c));
                end else begin
                    if (c == 0) mon_e = q0.pop_front();
                    else mon_e = q1.pop_front();
                    chk($sformatf("mon_count ch%0d", c), cnt_of(c), mon_e.pos);
                    chk($sformatf("mon_rev ch%0d", c), rev_of(c), longint'(mon_e.rev & 32'hFFFF));
                    chk($sformatf("mon_dir ch%0d", c), dir[c], mon_e.dir);
                    chk($sformatf("mon_wrap ch%0d", c), wrap[c], mon_e.wrp);
                    if (wrap[c]) wraps_seen[c]++;
                end
            end else if (wrap[c]) begin
                checks++;
                errors++;
                $display("FAIL wrap_without_step ch%0d: got wrap 1 expected 0", c);
            end
        end
    end

    initial begin
        seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;
        for (int c = 0; c < 2; c++) begin
            pos[c] = 0; rev[c] = 0; ph[c] = 0; wraps_seen[c] = 0;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_rev", rev_count, 0);
        chk("rst_dir", dir, 0);
        chk("rst_step_wrap", {step, wrap}, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);

        for (int i = 0; i < 10; i++) act(0, 1, 0, 0, early, st, wr);
        chk("cw10_count0", cnt_of(0), 2);
        chk("cw10_rev0", rev_of(0), 1);
        chk("cw10_dir0", dir[0], 1);
        chk("cw10_wraps0", wraps_seen[0], 1);
        chk("cw10_count1", cnt_of(1), 0);

        act(0, 0, 2, 0, early, st, wr);
        chk("clear_count0", cnt_of(0), 0);
        act(0, -1, 0, 0, early, st, wr);
        chk("ccw_latency_early", early, 0);
        chk("ccw_latency_step", st, 1);
        chk("ccw_wrap", wr, 1);
        chk("ccw_count0", cnt_of(0), 7);
        chk("ccw_rev0", rev_of(0), 16'hFFFF);
        chk("ccw_dir0", dir[0], 0);

        @(negedge clk);
        a[0] = ~a[0];
        repeat (2) @(negedge clk);
        a[0] = ~a[0];
        repeat (12) @(posedge clk);
        #1;
        chk("glitch_count0", cnt_of(0), pos[0]);
        act(0, 1, 0, 0, early, st, wr);
        chk("stable_step", st, 1);
        chk("stable_count0", cnt_of(0), pos[0]);

        act(1, 2, 0, 0, early, st, wr);
        chk("illegal_err1", err[1], 1);
        chk("illegal_nostep", st, 0);
        chk("illegal_count1", cnt_of(1), pos[1]);
        act(1, 2, 3, 0, early, st, wr);
        chk("errset_beats_clr", err[1], 1);
        @(negedge clk);
        err_clr[1] = 1'b1;
        @(posedge clk);
        #1;
        chk("err_clr_alone", err[1], 0);
        @(negedge clk);
        err_clr = '0;
        chk("err0_clean", err[0], 0);

        act(0, 1, 1, 5, early, st, wr);
        chk("load5_nostep", st, 0);
        chk("load5_count0", cnt_of(0), 5);
        act(0, 0, 1, 20, early, st, wr);
        chk("load20_sat", cnt_of(0), 7);
        act(0, 1, 2, 0, early, st, wr);
        chk("clear_step_nostep", st, 0);
        chk("clear_step_nowrap", wr, 0);
        chk("clear_step_count0", cnt_of(0), 0);
        chk("clear_step_rev0", rev_of(0), 0);

        for (int r = 0; r < 40; r++) begin
            int m;
            m = $urandom_range(1, 3);
            @(negedge clk);
            for (int c = 0; c < 2; c++) begin
                if (m[c]) apply_move(c, ($urandom_range(0, 1) == 1) ? 1 : -1, 1'b1);
            end
            repeat (9) @(posedge clk);
        end
        #1;
        chk("rand_count0", cnt_of(0), pos[0]);
        chk("rand_count1", cnt_of(1), pos[1]);
        chk("rand_rev1", rev_of(1), longint'(rev[1] & 32'hFFFF));

        while (ph[0] != 1) act(0, 1, 0, 0, early, st, wr);
        @(negedge clk);
        apply_move(0, 1, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_count", count, 0);
        chk("midrst_rev", rev_count, 0);
        chk("midrst_dir_err", {dir, err}, 0);
        for (int c = 0; c < 2; c++) begin pos[c] = 0; rev[c] = 0; end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        act(0, 1, 0, 0, early, st, wr);
        chk("prime_step", st, 1);
        chk("prime_count0", cnt_of(0), 1);
        chk("prime_err", err, 0);

        repeat (10) @(posedge clk);
        chk("sb_drained0", q0.size(), 0);
        chk("sb_drained1", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
